// File: rtl/fft_fp_pkg.sv
// Single-precision constants and helpers shared by the FFT float datapath
// (multiplier and adder stages).
package fft_fp_pkg;

   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;

   localparam logic [31:0]      FP_POS_ZERO = 32'h0000_0000;
   localparam logic [EXP_W-1:0] FP_INF_EXP  = 8'hFF;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exponent;
      logic [MAN_W-1:0] man;
   } fp_t;

   // Significand with the hidden bit restored; a zero exponent field flushes the operand to zero.
   function automatic logic [MAN_W:0] fp_sig(input fp_t f);
      return (f.exponent == '0) ? '0 : {1'b1, f.man};
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 27
) (
   input  logic [WIDTH-1:0]           value,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // Scanning upward lets the most significant set bit win.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            count = CNT_W'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage single-precision adder/subtractor (unpack/swap, align/add,
// normalize/pack) with truncation rounding and a global stall on backpressure.
module fp_add_pipe
   import fft_fp_pkg::*;
#(
   parameter int GUARD_BITS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   localparam int SIG_W  = MAN_W + 1;
   localparam int EXT_W  = SIG_W + GUARD_BITS;
   localparam int SUM_W  = EXT_W + 1;
   localparam int LZC_W  = $clog2(EXT_W + 1);
   localparam int NEXP_W = EXP_W + 2;

   localparam logic [EXP_W-1:0]         SHIFT_LIMIT = EXP_W'(EXT_W);
   localparam logic signed [NEXP_W-1:0] EXP_ZERO_S  = '0;
   localparam logic signed [NEXP_W-1:0] EXP_INF_S   = NEXP_W'(FP_INF_EXP);

   logic adv;

   logic             s1_valid;
   logic             s1_sign;
   logic             s1_sub;
   logic [EXP_W-1:0] s1_exp;
   logic [EXP_W-1:0] s1_shift;
   logic [SIG_W-1:0] s1_sig_a;
   logic [SIG_W-1:0] s1_sig_b;

   logic             s2_valid;
   logic             s2_sign;
   logic [EXP_W-1:0] s2_exp;
   logic [SUM_W-1:0] s2_sum;

   logic        s3_valid;
   logic [31:0] s3_result;

   assign adv       = !s3_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = s3_valid;
   assign result    = s3_result;

   // ---------------- S1: unpack and order by magnitude ----------------
   fp_t                  op_a;
   fp_t                  op_b;
   fp_t                  op_hi;
   fp_t                  op_lo;
   logic [EXP_W+MAN_W:0] key_a;
   logic [EXP_W+MAN_W:0] key_b;
   logic                 swap;

   assign op_a  = num1;
   assign op_b  = {num2[31] ^ sub, num2[30:0]};
   assign key_a = {op_a.exponent, fp_sig(op_a)};
   assign key_b = {op_b.exponent, fp_sig(op_b)};
   assign swap  = key_b > key_a;
   assign op_hi = swap ? op_b : op_a;
   assign op_lo = swap ? op_a : op_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sign  <= op_hi.sign;
         s1_sub   <= op_hi.sign ^ op_lo.sign;
         s1_exp   <= op_hi.exponent;
         s1_shift <= op_hi.exponent - op_lo.exponent;
         s1_sig_a <= fp_sig(op_hi);
         s1_sig_b <= fp_sig(op_lo);
      end
   end

   // ---------------- S2: align the smaller operand and add ----------------
   logic [EXT_W-1:0] ext_a;
   logic [EXT_W-1:0] ext_b;
   logic [SUM_W-1:0] sum_next;

   always_comb begin
      ext_a = {s1_sig_a, {GUARD_BITS{1'b0}}};
      ext_b = {s1_sig_b, {GUARD_BITS{1'b0}}};
      if (s1_shift >= SHIFT_LIMIT) begin
         ext_b = '0;
      end else begin
         ext_b = ext_b >> s1_shift;
      end
      if (s1_sub) begin
         sum_next = {1'b0, ext_a} - {1'b0, ext_b};
      end else begin
         sum_next = {1'b0, ext_a} + {1'b0, ext_b};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s2_sign <= s1_sign;
         s2_exp  <= s1_exp;
         s2_sum  <= sum_next;
      end
   end

   // ---------------- S3: normalize, truncate and pack ----------------
   logic [LZC_W-1:0]         lz_count;
   logic [NEXP_W-1:0]        exp_wide;
   logic [EXT_W-1:0]         norm_sig;
   logic signed [NEXP_W-1:0] norm_exp;
   logic [31:0]              result_next;

   fp_lzc #(
      .WIDTH (EXT_W)
   ) u_lzc (
      .value (s2_sum[EXT_W-1:0]),
      .count (lz_count)
   );

   assign exp_wide = {2'b00, s2_exp};

   always_comb begin
      if (s2_sum[SUM_W-1]) begin
         norm_sig = s2_sum[SUM_W-1:1];
         norm_exp = $signed(exp_wide + NEXP_W'(1));
      end else begin
         norm_sig = s2_sum[EXT_W-1:0] << lz_count;
         norm_exp = $signed(exp_wide - NEXP_W'(lz_count));
      end

      // Exact cancellation is always +0; underflow keeps the sign of the larger operand.
      if (s2_sum == '0) begin
         result_next = FP_POS_ZERO;
      end else if (norm_exp <= EXP_ZERO_S) begin
         result_next = {s2_sign, 31'b0};
      end else if (norm_exp >= EXP_INF_S) begin
         result_next = {s2_sign, FP_INF_EXP, {MAN_W{1'b0}}};
      end else begin
         result_next = {s2_sign, norm_exp[EXP_W-1:0], norm_sig[EXT_W-2 -: MAN_W]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid  <= 1'b0;
         s3_result <= FP_POS_ZERO;
      end else if (adv) begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            s3_result <= result_next;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: directed vectors, backpressure and
// reset sequences, then a random stream against a truncating integer model.
module tb_fp_add_pipe;

   localparam int G = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] num1;
   logic [31:0] num2;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   fp_add_pipe #(
      .GUARD_BITS (G)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub_op;
      logic [31:0] want;
   } vec_t;

   vec_t        vecs[$];
   vec_t        pairs[$];
   logic [31:0] exp_q[$];

   // Truncating reference: exact integer magnitudes scaled by 2^G, smaller one floored on alignment.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub_op);
      logic   sa, sb, ts;
      int     ea, eb, te, e, msb;
      longint ma, mb, tm, sum, frac;
      sa = a[31];
      sb = b[31] ^ sub_op;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = (ea == 0) ? 64'd0 : ((64'd1 << 23) | longint'(a[22:0]));
      mb = (eb == 0) ? 64'd0 : ((64'd1 << 23) | longint'(b[22:0]));
      if (mb > 0 && (ma == 0 || eb > ea || (eb == ea && mb > ma))) begin
         ts = sa; sa = sb; sb = ts;
         te = ea; ea = eb; eb = te;
         tm = ma; ma = mb; mb = tm;
      end
      if (ma == 0) return 32'h0;
      ma = ma << G;
      mb = (eb == 0 || ea - eb >= 60) ? 64'd0 : ((mb << G) >> (ea - eb));
      sum = (sa != sb) ? (ma - mb) : (ma + mb);
      if (sum == 0) return 32'h0;
      msb = 0;
      while ((sum >> (msb + 1)) != 0) msb++;
      e = ea + msb - (23 + G);
      if (msb >= 23 + G) sum = sum >> (msb - 23 - G);
      else               sum = sum << (23 + G - msb);
      frac = (sum >> G) & 64'h7F_FFFF;
      if (e <= 0)   return {sa, 31'b0};
      if (e >= 255) return {sa, 8'hFF, 23'b0};
      return {sa, e[7:0], frac[22:0]};
   endfunction

   function automatic vec_t mk_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub_op, input logic [31:0] want);
      vec_t v;
      v.name = name; v.a = a; v.b = b; v.sub_op = sub_op; v.want = want;
      return v;
   endfunction

   function automatic int clamp_exp(input int e);
      return (e < 1) ? 1 : ((e > 254) ? 254 : e);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
      end
   endtask

   // One clock cycle: drive at the falling edge, observe 1 time unit later.
   task automatic applyStimulus(input logic rst_val, input logic v, input logic [31:0] a,
                                input logic [31:0] b, input logic s, input logic r,
                                output logic accepted, output logic retired, output logic [31:0] res);
      @(negedge clk);
      rst = rst_val; in_valid = v; num1 = a; num2 = b; sub = s; out_ready = r;
      #1;
      accepted = v && in_ready && !rst_val;
      retired  = out_valid && r && !rst_val;
      res      = result;
   endtask

   task automatic run_single(input vec_t v);
      logic        acc, ret;
      logic [31:0] res, got;
      int          lat;
      applyStimulus(0, 1, v.a, v.b, v.sub_op, 1, acc, ret, res);
      checkOutput({v.name, "_accept"}, 32'(acc), 32'd1);
      lat = 0;
      got = 32'hDEAD_BEEF;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
         if (ret) begin
            lat = c;
            got = res;
         end
      end
      checkOutput({v.name, "_latency"}, 32'(lat), 32'd3);
      checkOutput({v.name, "_result"}, got, v.want);
   endtask

   logic        acc, ret, prev_stall;
   logic [31:0] res, prev_res, a_r, b_r;
   int          k, got, stale, n_acc, n_ret, idx, ea, eb, mode;
   logic        v_r, s_r, r_r;

   initial begin
      vecs.push_back(mk_vec("one_plus_one",   32'h3F800000, 32'h3F800000, 0, 32'h40000000));
      vecs.push_back(mk_vec("one_minus_3q",   32'h3F800000, 32'h3F400000, 1, 32'h3E800000));
      vecs.push_back(mk_vec("cancel",         32'h40400000, 32'h40400000, 1, 32'h00000000));
      vecs.push_back(mk_vec("align_out",      32'h3F800000, 32'h30800000, 0, 32'h3F800000));
      vecs.push_back(mk_vec("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000));
      vecs.push_back(mk_vec("underflow",      32'h00800000, 32'h00C00000, 1, 32'h80000000));
      vecs.push_back(mk_vec("neg_two_plus_1", 32'hC0000000, 32'h3F800000, 0, 32'hBF800000));
      vecs.push_back(mk_vec("sub_negative",   32'h3F800000, 32'hBF800000, 1, 32'h40000000));
      vecs.push_back(mk_vec("neg_zero_zero",  32'h80000000, 32'h00000000, 0, 32'h00000000));
      vecs.push_back(mk_vec("denorm_flush",   32'h00000001, 32'h3F800000, 0, 32'h3F800000));
      vecs.push_back(mk_vec("trunc_add",      32'h3F800001, 32'h33800000, 0, 32'h3F800001));
      vecs.push_back(mk_vec("guard_sub",      32'h3F800000, 32'h33800000, 1, 32'h3F7FFFFF));

      pairs.push_back(mk_vec("bp0", 32'h3F800000, 32'h3F800000, 0, 32'h40000000));
      pairs.push_back(mk_vec("bp1", 32'h40400000, 32'h3F800000, 0, 32'h40800000));
      pairs.push_back(mk_vec("bp2", 32'hC0000000, 32'h3F800000, 0, 32'hBF800000));
      pairs.push_back(mk_vec("bp3", 32'h3FC00000, 32'h3FC00000, 0, 32'h40400000));
      pairs.push_back(mk_vec("bp4", 32'h3F800000, 32'h3F400000, 1, 32'h3E800000));

      // Reset state
      applyStimulus(1, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
      applyStimulus(1, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_result", result, 32'h0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] directed vectors");
      foreach (vecs[i]) run_single(vecs[i]);

      $display("[TB] backpressure sequence");
      k = 0;
      for (int c = 0; c < 6; c++) begin
         idx = (k < 5) ? k : 4;
         applyStimulus(0, 1, pairs[idx].a, pairs[idx].b, pairs[idx].sub_op, 0, acc, ret, res);
         if (acc) k++;
      end
      checkOutput("bp_accept_count", 32'(k), 32'd3);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(0, 1, pairs[k].a, pairs[k].b, pairs[k].sub_op, 0, acc, ret, res);
         checkOutput($sformatf("bp_hold%0d", c), res, pairs[0].want);
      end
      got = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         idx = (k < 5) ? k : 4;
         applyStimulus(0, k < 5, pairs[idx].a, pairs[idx].b, pairs[idx].sub_op, 1, acc, ret, res);
         if (ret) begin
            checkOutput($sformatf("bp_out%0d", got), res, pairs[got].want);
            checkOutput($sformatf("bp_out%0d_cycle", got), 32'(c), 32'(got));
            got++;
         end
         if (acc) k++;
      end
      checkOutput("bp_drain_count", 32'(got), 32'd5);

      $display("[TB] reset with operations in flight");
      k = 0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 1, pairs[c].a, pairs[c].b, pairs[c].sub_op, 0, acc, ret, res);
         if (acc) k++;
      end
      checkOutput("flush_inflight", 32'(k), 32'd3);
      applyStimulus(1, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_result", result, 32'h0);
      checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
      stale = ret ? 1 : 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
         if (ret) stale++;
      end
      checkOutput("flush_no_stale", 32'(stale), 32'd0);
      run_single(mk_vec("after_flush", 32'h3F800000, 32'h3F400000, 1, 32'h3E800000));

      $display("[TB] random stream");
      n_acc = 0; n_ret = 0; prev_stall = 0; prev_res = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         mode = int'($urandom_range(0, 9));
         ea = (mode == 9) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 254));
         if (mode == 0)      eb = 0;
         else if (mode < 6)  eb = clamp_exp(ea + int'($urandom_range(0, 6)) - 3);
         else                eb = int'($urandom_range(1, 254));
         if (mode == 8) ea = 0;
         a_r = {1'($urandom), 8'(ea), 23'($urandom)};
         b_r = (mode == 1) ? a_r : {1'($urandom), 8'(eb), 23'($urandom)};
         s_r = 1'($urandom);
         v_r = ($urandom_range(0, 9) < 7);
         r_r = ($urandom_range(0, 9) < 6);
         applyStimulus(0, v_r, a_r, b_r, s_r, r_r, acc, ret, res);
         if (prev_stall) checkOutput("stall_stable", res, prev_res);
         prev_stall = out_valid && !r_r;
         prev_res   = res;
         if (ret) begin
            n_ret++;
            if (exp_q.size() > 0) checkOutput($sformatf("rand_result%0d", n_ret), res, exp_q.pop_front());
         end
         if (acc) begin
            n_acc++;
            exp_q.push_back(ref_add(a_r, b_r, s_r));
         end
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
         if (ret) begin
            n_ret++;
            checkOutput($sformatf("rand_result%0d", n_ret), res, exp_q.pop_front());
         end
      end
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, acc, ret, res);
      if (ret) n_ret++;
      checkOutput("rand_count", 32'(n_ret), 32'(n_acc));
      checkOutput("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
